// File: rtl/sim_halt_dumper_if.sv
// Dump stream port of sim_halt_dumper: registered valid/ready word with a 2-bit tag
// (0 = PC, 1 = register, 2 = memory, 3 = end marker).
interface sim_halt_dumper_if #(
  parameter int DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_tag;
  logic [DATA_W-1:0] out_data;

  modport master (output out_valid, out_tag, out_data, input out_ready);
  modport slave  (input out_valid, out_tag, out_data, output out_ready);
endinterface

// File: rtl/sim_halt_dumper.sv
// End-of-run capture/dump engine: traces PCs, halts on zero instruction or timeout, then streams
// trace, registers, memory window and an end word. Macro DUMPER_CHECKSUM_EN makes the end word an XOR checksum.
module sim_halt_dumper #(
  parameter int          DATA_W         = 32,
  parameter int          TRACE_DEPTH    = 16,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter int          NUM_REGS       = 32,
  parameter logic [31:0] MEM_BASE       = 32'h4000,
  parameter int          MEM_WORDS      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           pc,
  input  logic [DATA_W-1:0]           inst,
  output logic [$clog2(NUM_REGS)-1:0] rf_raddr,
  input  logic [DATA_W-1:0]           rf_rdata,
  output logic [31:0]                 mem_addr,
  input  logic [DATA_W-1:0]           mem_rdata,
  sim_halt_dumper_if.master           dump,
  output logic                        done
);
  localparam int TP_W  = $clog2(TRACE_DEPTH);
  localparam int CNT_W = TP_W + 1;
  localparam int CYC_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RA_W  = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    ST_RUN, ST_DUMP_PC, ST_DUMP_REG, ST_DUMP_MEM, ST_END, ST_FLUSH, ST_DONE
  } state_t;

  state_t            state, state_n;
  logic [TP_W-1:0]   wp, wp_n;
  logic              wrapped, wrapped_n;
  logic [CYC_W-1:0]  cyc, cyc_n;
  logic [CNT_W-1:0]  pcnt, pcnt_n;
  logic              valid_q, valid_n;
  logic [1:0]        tag_q, tag_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic [RA_W-1:0]   raddr_q, raddr_n;
  logic [31:0]       maddr_q, maddr_n;
  logic              done_q, done_n;
  logic [DATA_W-1:0] trace [TRACE_DEPTH];

  logic              load, halt;
  logic [CNT_W-1:0]  pc_total;
  logic [TP_W-1:0]   rp;
  logic [DATA_W-1:0] end_word;

  assign load     = !valid_q || dump.out_ready;
  assign halt     = (inst == '0) || (cyc == CYC_W'(TIMEOUT_CYCLES - 1));
  // Oldest entry is at wp once the buffer has wrapped, otherwise at 0.
  assign pc_total = wrapped ? CNT_W'(TRACE_DEPTH) : {1'b0, wp};
  assign rp       = (wrapped ? wp : '0) + pcnt[TP_W-1:0];

`ifdef DUMPER_CHECKSUM_EN
  logic [DATA_W-1:0] csum, csum_n;
  assign end_word = csum;

  always_ff @(posedge clk) begin
    if (reset) csum <= '0;
    else       csum <= csum_n;
  end
`else
  assign end_word = DATA_W'(cyc);
`endif

  always_ff @(posedge clk) begin
    if (!reset && state == ST_RUN) trace[wp] <= pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_RUN;
      wp      <= '0;
      wrapped <= 1'b0;
      cyc     <= '0;
      pcnt    <= '0;
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      raddr_q <= '0;
      maddr_q <= MEM_BASE;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      wp      <= wp_n;
      wrapped <= wrapped_n;
      cyc     <= cyc_n;
      pcnt    <= pcnt_n;
      valid_q <= valid_n;
      tag_q   <= tag_n;
      data_q  <= data_n;
      raddr_q <= raddr_n;
      maddr_q <= maddr_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    wp_n      = wp;
    wrapped_n = wrapped;
    cyc_n     = cyc;
    pcnt_n    = pcnt;
    valid_n   = valid_q;
    tag_n     = tag_q;
    data_n    = data_q;
    raddr_n   = raddr_q;
    maddr_n   = maddr_q;
    done_n    = done_q;
    unique case (state)
      ST_RUN: begin
        wp_n = wp + TP_W'(1);
        if (wp == TP_W'(TRACE_DEPTH - 1)) wrapped_n = 1'b1;
        if (cyc != CYC_W'(TIMEOUT_CYCLES)) cyc_n = cyc + CYC_W'(1);
        if (halt) state_n = ST_DUMP_PC;
      end
      ST_DUMP_PC: if (load) begin
        valid_n = 1'b1;
        tag_n   = 2'd0;
        data_n  = trace[rp];
        pcnt_n  = pcnt + CNT_W'(1);
        if (pcnt == pc_total - CNT_W'(1)) state_n = ST_DUMP_REG;
      end
      ST_DUMP_REG: if (load) begin
        valid_n = 1'b1;
        tag_n   = 2'd1;
        data_n  = rf_rdata;
        raddr_n = raddr_q + RA_W'(1);
        if (raddr_q == RA_W'(NUM_REGS - 1)) state_n = ST_DUMP_MEM;
      end
      ST_DUMP_MEM: if (load) begin
        valid_n = 1'b1;
        tag_n   = 2'd2;
        data_n  = mem_rdata;
        maddr_n = maddr_q + 32'd1;
        if (maddr_q == MEM_BASE + 32'(MEM_WORDS - 1)) state_n = ST_END;
      end
      ST_END: if (load) begin
        valid_n = 1'b1;
        tag_n   = 2'd3;
        data_n  = end_word;
        state_n = ST_FLUSH;
      end
      ST_FLUSH: if (dump.out_ready) begin
        valid_n = 1'b0;
        done_n  = 1'b1;
        state_n = ST_DONE;
      end
      default: ;
    endcase
  end

`ifdef DUMPER_CHECKSUM_EN
  always_comb begin
    csum_n = csum;
    if (load && (state inside {ST_DUMP_PC, ST_DUMP_REG, ST_DUMP_MEM})) csum_n = csum ^ data_n;
  end
`endif

  assign dump.out_valid = valid_q;
  assign dump.out_tag   = tag_q;
  assign dump.out_data  = data_q;
  assign rf_raddr       = raddr_q;
  assign mem_addr       = maddr_q;
  assign done           = done_q;
endmodule
